// File: rtl/vram_blit_arbiter.sv
// VRAM port-A arbiter: the CPU Avalon slave always wins; a blit engine (screen fill and
// scroll-up-by-N-rows) uses only the cycles the CPU leaves idle.
module vram_blit_arbiter #(
  parameter int WORDS_PER_ROW = 40,
  parameter int ROWS          = 30,
  parameter int ADDR_W        = 12
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              AVL_CS,
  input  logic              AVL_READ,
  input  logic              AVL_WRITE,
  input  logic [3:0]        AVL_BYTE_EN,
  input  logic [ADDR_W-1:0] AVL_ADDR,
  input  logic [31:0]       AVL_WRITEDATA,
  output logic [31:0]       AVL_READDATA,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [3:0]        RAM_BYTE_EN,
  output logic [31:0]       RAM_WDATA,
  output logic              RAM_WREN,
  input  logic [31:0]       RAM_RDATA,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_OP,
  input  logic [4:0]        CMD_ROWS,
  input  logic [31:0]       CMD_FILL,
  output logic              BUSY,
  output logic              DONE
);

  localparam logic [ADDR_W-1:0] T_W    = ADDR_W'(WORDS_PER_ROW * ROWS);
  localparam logic [ADDR_W-1:0] WPR_W  = ADDR_W'(WORDS_PER_ROW);
  localparam logic [ADDR_W-1:0] ROWS_W = ADDR_W'(ROWS);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_RWAIT, S_WR, S_FILL, S_DONE} state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] dst, dst_p1, off_q, k_q;
  logic [31:0]       fill_q, hold;
  logic              cpu_req, accept, dst_inc, hold_en;
  logic [ADDR_W-1:0] rows_ext, n_acc, off_acc, k_acc;
  logic [ADDR_W-1:0] eng_addr;
  logic [31:0]       eng_wdata;
  logic              eng_wren;

  assign cpu_req   = AVL_CS & (AVL_READ | AVL_WRITE);
  assign CMD_READY = (state == S_IDLE);
  assign BUSY      = (state != S_IDLE);
  assign DONE      = (state == S_DONE);
  assign accept    = CMD_VALID & CMD_READY;
  assign dst_p1    = dst + ADDR_W'(1);

  // Fill, or a scroll of a whole screen or more, degenerates to N = ROWS (no copy phase).
  assign rows_ext = ADDR_W'(CMD_ROWS);
  assign n_acc    = (!CMD_OP || rows_ext >= ROWS_W) ? ROWS_W : rows_ext;
  assign off_acc  = n_acc * WPR_W;
  assign k_acc    = T_W - off_acc;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state  <= S_IDLE;
      dst    <= '0;
      off_q  <= '0;
      k_q    <= '0;
      fill_q <= '0;
      hold   <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        dst    <= '0;
        off_q  <= off_acc;
        k_q    <= k_acc;
        fill_q <= CMD_FILL;
      end else if (dst_inc) begin
        dst <= dst_p1;
      end
      if (hold_en) hold <= RAM_RDATA;
    end
  end

  always_comb begin
    state_d   = state;
    dst_inc   = 1'b0;
    hold_en   = 1'b0;
    eng_addr  = dst;
    eng_wren  = 1'b0;
    eng_wdata = (state == S_FILL) ? fill_q : hold;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (n_acc == '0)      state_d = S_DONE;
          else if (k_acc == '0) state_d = S_FILL;
          else                  state_d = S_RD;
        end
      end
      S_RD: begin
        eng_addr = dst + off_q;
        if (!cpu_req) state_d = S_RWAIT;
      end
      // Read data arrives regardless of who owns the port this cycle.
      S_RWAIT: begin
        hold_en = 1'b1;
        state_d = S_WR;
      end
      S_WR: begin
        if (!cpu_req) begin
          eng_wren = 1'b1;
          dst_inc  = 1'b1;
          state_d  = (dst_p1 == k_q) ? S_FILL : S_RD;
        end
      end
      S_FILL: begin
        if (!cpu_req) begin
          eng_wren = 1'b1;
          dst_inc  = 1'b1;
          if (dst_p1 == T_W) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign RAM_ADDR     = cpu_req ? AVL_ADDR      : eng_addr;
  assign RAM_BYTE_EN  = cpu_req ? AVL_BYTE_EN   : 4'hF;
  assign RAM_WDATA    = cpu_req ? AVL_WRITEDATA : eng_wdata;
  assign RAM_WREN     = cpu_req ? (AVL_CS & AVL_WRITE) : eng_wren;
  assign AVL_READDATA = RAM_RDATA;

endmodule
